rf_read_stage: RTL and testbench

RF_READ_STAGE -- requirements
Module: rf_read_stage

---
 rtl/rf_read_stage_if.sv | 64 ++++++
 rtl/rf_read_stage.sv | 124 ++++++++++++
 tb/tb_rf_read_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_read_stage_if.sv
// Bundle of the RF-read stage pipeline signals: ID/RF inputs, register-file read port,
// writeback completion port, stall/flush control and the registered RF/EX outputs.
interface rf_read_stage_if;
  logic [15:0] PC_in;
  logic [15:0] PC_plus2_in;
  logic [2:0]  WB_in;
  logic [1:0]  Memory_in;
  logic [3:0]  Ex_in;
  logic [3:0]  opcode_in;
  logic [3:0]  src1_in;
  logic [3:0]  src2_in;
  logic [2:0]  dest_in;
  logic [8:0]  imm9_in;
  logic [5:0]  imm6_in;
  logic        imm_controller_in;
  logic        Valid_in;

  logic [2:0]  rf_addr1;
  logic [2:0]  rf_addr2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;

  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;

  logic        ex_stall;
  logic        flush;
  logic        stall_out;

  logic [15:0] PC_out;
  logic [15:0] PC_plus2_out;
  logic [2:0]  WB_out;
  logic [1:0]  Memory_out;
  logic [3:0]  Ex_out;
  logic [3:0]  opcode_out;
  logic [2:0]  dest_out;
  logic [15:0] opA_out;
  logic [15:0] opB_out;
  logic [15:0] imm16_out;
  logic        Valid_out;

  modport master (
    output PC_in, PC_plus2_in, WB_in, Memory_in, Ex_in, opcode_in, src1_in, src2_in,
           dest_in, imm9_in, imm6_in, imm_controller_in, Valid_in,
    input  rf_addr1, rf_addr2,
    output rf_data1, rf_data2,
    output wb_valid, wb_dest, wb_data, ex_stall, flush,
    input  stall_out,
    input  PC_out, PC_plus2_out, WB_out, Memory_out, Ex_out, opcode_out, dest_out,
           opA_out, opB_out, imm16_out, Valid_out
  );

  modport slave (
    input  PC_in, PC_plus2_in, WB_in, Memory_in, Ex_in, opcode_in, src1_in, src2_in,
           dest_in, imm9_in, imm6_in, imm_controller_in, Valid_in,
    output rf_addr1, rf_addr2,
    input  rf_data1, rf_data2,
    input  wb_valid, wb_dest, wb_data, ex_stall, flush,
    output stall_out,
    output PC_out, PC_plus2_out, WB_out, Memory_out, Ex_out, opcode_out, dest_out,
           opA_out, opB_out, imm16_out, Valid_out
  );
endinterface

// File: rtl/rf_read_stage.sv
// Register-read pipeline stage with an 8-entry busy scoreboard, hazard stall and RF/EX register.
// Define RF_BYPASS_EN to forward same-cycle writeback data into a blocked operand.
module rf_read_stage (
  input  logic           clock,
  input  logic           reset,
  rf_read_stage_if.slave bus
);

  function automatic logic signed [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic signed [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  logic [7:0]  busy;
  logic [7:0]  set_vec;
  logic [7:0]  clr_vec;
  logic        byp1;
  logic        byp2;
  logic        blk1;
  logic        blk2;
  logic        stall;
  logic        issue;
  logic [15:0] opa;
  logic [15:0] opb;
  logic signed [15:0] imm16;

  logic [15:0] pc_p1;
  logic [15:0] pc_plus2_p1;
  logic [2:0]  wb_p1;
  logic [1:0]  mem_p1;
  logic [3:0]  ex_p1;
  logic [3:0]  opcode_p1;
  logic [2:0]  dest_p1;
  logic [15:0] opa_p1;
  logic [15:0] opb_p1;
  logic [15:0] imm16_p1;
  logic        vld_p1;

  assign bus.rf_addr1 = bus.src1_in[2:0];
  assign bus.rf_addr2 = bus.src2_in[2:0];

  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef RF_BYPASS_EN
    byp1 = bus.wb_valid && (bus.wb_dest == bus.src1_in[2:0]);
    byp2 = bus.wb_valid && (bus.wb_dest == bus.src2_in[2:0]);
`endif
    // Busy is the registered value, so a dest==src instruction never blocks on itself.
    blk1  = bus.src1_in[3] && busy[bus.src1_in[2:0]] && !byp1;
    blk2  = bus.src2_in[3] && busy[bus.src2_in[2:0]] && !byp2;
    stall = bus.Valid_in && (blk1 || blk2 || bus.ex_stall);
    issue = bus.Valid_in && !stall && !bus.flush;

    opa = 16'd0;
    if (bus.src1_in[3]) opa = byp1 ? bus.wb_data : bus.rf_data1;
    opb = 16'd0;
    if (bus.src2_in[3]) opb = byp2 ? bus.wb_data : bus.rf_data2;
    imm16 = bus.imm_controller_in ? sext9(bus.imm9_in) : sext6(bus.imm6_in);

    set_vec = 8'd0;
    if (issue && bus.WB_in[0]) set_vec[bus.dest_in] = 1'b1;
    clr_vec = 8'd0;
    if (bus.wb_valid) clr_vec[bus.wb_dest] = 1'b1;
  end

  assign bus.stall_out = stall;

  // Scoreboard: set wins over a same-cycle clear of the same bit.
  always_ff @(posedge clock) begin
    if (reset) busy <= 8'd0;
    else       busy <= (busy & ~clr_vec) | set_vec;
  end

  // ---- RF/EX boundary (p1) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p1       <= 16'd0;
      pc_plus2_p1 <= 16'd0;
      wb_p1       <= 3'd0;
      mem_p1      <= 2'd0;
      ex_p1       <= 4'd0;
      opcode_p1   <= 4'b1111;
      dest_p1     <= 3'd0;
      opa_p1      <= 16'd0;
      opb_p1      <= 16'd0;
      imm16_p1    <= 16'd0;
      vld_p1      <= 1'b0;
    end else if (issue) begin
      pc_p1       <= bus.PC_in;
      pc_plus2_p1 <= bus.PC_plus2_in;
      wb_p1       <= bus.WB_in;
      mem_p1      <= bus.Memory_in;
      ex_p1       <= bus.Ex_in;
      opcode_p1   <= bus.opcode_in;
      dest_p1     <= bus.dest_in;
      opa_p1      <= opa;
      opb_p1      <= opb;
      imm16_p1    <= imm16;
      vld_p1      <= 1'b1;
    end else if (bus.flush || !bus.ex_stall) begin
      wb_p1       <= 3'd0;
      mem_p1      <= 2'd0;
      opcode_p1   <= 4'b1111;
      vld_p1      <= 1'b0;
    end
  end

  assign bus.PC_out       = pc_p1;
  assign bus.PC_plus2_out = pc_plus2_p1;
  assign bus.WB_out       = wb_p1;
  assign bus.Memory_out   = mem_p1;
  assign bus.Ex_out       = ex_p1;
  assign bus.opcode_out   = opcode_p1;
  assign bus.dest_out     = dest_p1;
  assign bus.opA_out      = opa_p1;
  assign bus.opB_out      = opb_p1;
  assign bus.imm16_out    = imm16_p1;
  assign bus.Valid_out    = vld_p1;

endmodule

// File: tb/tb_rf_read_stage.sv
// Directed bench for rf_read_stage: hazards, bubbles, immediates, ex_stall hold, flush, reset.
module tb_rf_read_stage;
  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  rf_read_stage_if bus ();

  rf_read_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register-file model: register i holds 16'hA000 + i.
  assign bus.rf_data1 = 16'hA000 + {13'd0, bus.rf_addr1};
  assign bus.rf_data2 = 16'hA000 + {13'd0, bus.rf_addr2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic [15:0] pc, input logic [2:0] wb, input logic [3:0] opc,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [2:0] dst);
    bus.Valid_in    = 1'b1;
    bus.PC_in       = pc;
    bus.PC_plus2_in = pc + 16'd2;
    bus.WB_in       = wb;
    bus.Memory_in   = 2'b01;
    bus.Ex_in       = 4'h5;
    bus.opcode_in   = opc;
    bus.src1_in     = s1;
    bus.src2_in     = s2;
    bus.dest_in     = dst;
  endtask

  task automatic chk_bubble(input string tag);
    check({tag, ".valid"}, bus.Valid_out, 1'b0);
    check({tag, ".opcode"}, bus.opcode_out, 4'b1111);
    check({tag, ".wb"}, bus.WB_out, 3'd0);
    check({tag, ".mem"}, bus.Memory_out, 2'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk_bubble(tag);
    check({tag, ".pc"}, bus.PC_out, 16'd0);
    check({tag, ".pc2"}, bus.PC_plus2_out, 16'd0);
    check({tag, ".ex"}, bus.Ex_out, 4'd0);
    check({tag, ".dest"}, bus.dest_out, 3'd0);
    check({tag, ".opA"}, bus.opA_out, 16'd0);
    check({tag, ".opB"}, bus.opB_out, 16'd0);
    check({tag, ".imm"}, bus.imm16_out, 16'd0);
    check({tag, ".busy"}, dut.busy, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.Valid_in = 1'b0; bus.PC_in = '0; bus.PC_plus2_in = '0; bus.WB_in = '0;
    bus.Memory_in = '0; bus.Ex_in = '0; bus.opcode_in = '0; bus.src1_in = '0;
    bus.src2_in = '0; bus.dest_in = '0; bus.imm9_in = '0; bus.imm6_in = '0;
    bus.imm_controller_in = 1'b0; bus.wb_valid = 1'b0; bus.wb_dest = '0;
    bus.wb_data = '0; bus.ex_stall = 1'b0; bus.flush = 1'b0;
    tick(); tick();
    chk_reset("rst0");
    check("rst0.stall", bus.stall_out, 1'b0);
    reset = 1'b0;

    // ADD r3 <- r1, r2 with imm9 = 1F0
    instr(16'h0010, 3'b001, 4'h0, 4'b1001, 4'b1010, 3'd3);
    bus.imm_controller_in = 1'b1; bus.imm9_in = 9'h1F0;
    #1;
    check("add.addr1", bus.rf_addr1, 3'd1);
    check("add.addr2", bus.rf_addr2, 3'd2);
    check("add.stall", bus.stall_out, 1'b0);
    tick();
    check("add.valid", bus.Valid_out, 1'b1);
    check("add.pc", bus.PC_out, 16'h0010);
    check("add.pc2", bus.PC_plus2_out, 16'h0012);
    check("add.opA", bus.opA_out, 16'hA001);
    check("add.opB", bus.opB_out, 16'hA002);
    check("add.imm", bus.imm16_out, 16'hFFF0);
    check("add.dest", bus.dest_out, 3'd3);
    check("add.wb", bus.WB_out, 3'b001);
    check("add.busy", dut.busy, 8'h08);

    // dependent on r3, src2 unused, imm6 = 1F
    instr(16'h0014, 3'b001, 4'h1, 4'b1011, 4'b0000, 3'd4);
    bus.imm_controller_in = 1'b0; bus.imm6_in = 6'h1F;
    #1;
    check("dep.stall0", bus.stall_out, 1'b1);
    tick();
    chk_bubble("dep.bub0");
    check("dep.stall1", bus.stall_out, 1'b1);
    tick();
    chk_bubble("dep.bub1");
    bus.wb_valid = 1'b1; bus.wb_dest = 3'd3; bus.wb_data = 16'hBEEF;
    #1;
`ifdef RF_BYPASS_EN
    check("dep.byp.stall", bus.stall_out, 1'b0);
    tick();
    bus.wb_valid = 1'b0;
    check("dep.byp.valid", bus.Valid_out, 1'b1);
    check("dep.byp.opA", bus.opA_out, 16'hBEEF);
`else
    check("dep.nobyp.stall", bus.stall_out, 1'b1);
    tick();
    bus.wb_valid = 1'b0;
    chk_bubble("dep.nobyp.bub");
    check("dep.nobyp.busy", dut.busy, 8'h00);
    #1;
    check("dep.nobyp.stall2", bus.stall_out, 1'b0);
    tick();
    check("dep.nobyp.valid", bus.Valid_out, 1'b1);
    check("dep.nobyp.opA", bus.opA_out, 16'hA003);
`endif
    check("dep.opB", bus.opB_out, 16'h0000);
    check("dep.imm", bus.imm16_out, 16'h001F);
    check("dep.pc", bus.PC_out, 16'h0014);
    check("dep.busy", dut.busy, 8'h10);

    // idle cycle retiring r4
    bus.Valid_in = 1'b0; bus.wb_valid = 1'b1; bus.wb_dest = 3'd4;
    #1;
    check("idle.stall", bus.stall_out, 1'b0);
    tick();
    bus.wb_valid = 1'b0;
    chk_bubble("idle");
    check("idle.busy", dut.busy, 8'h00);

    // imm9 positive, no sources used
    instr(16'h0020, 3'b000, 4'h2, 4'b0000, 4'b0000, 3'd0);
    bus.imm_controller_in = 1'b1; bus.imm9_in = 9'h0FF;
    tick();
    check("imm9.valid", bus.Valid_out, 1'b1);
    check("imm9.imm", bus.imm16_out, 16'h00FF);
    check("imm9.mem", bus.Memory_out, 2'b01);
    check("imm9.opA", bus.opA_out, 16'h0000);

    // ex_stall held for three cycles
    instr(16'h0030, 3'b001, 4'h3, 4'b0000, 4'b0000, 3'd6);
    bus.imm_controller_in = 1'b0; bus.imm6_in = 6'h20;
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("exs.stall", bus.stall_out, 1'b1);
      tick();
      check("exs.valid", bus.Valid_out, 1'b1);
      check("exs.pc", bus.PC_out, 16'h0020);
      check("exs.imm", bus.imm16_out, 16'h00FF);
      check("exs.opcode", bus.opcode_out, 4'h2);
      check("exs.busy", dut.busy, 8'h00);
    end
    bus.ex_stall = 1'b0;
    #1;
    check("exs.rel.stall", bus.stall_out, 1'b0);
    tick();
    check("exs.rel.valid", bus.Valid_out, 1'b1);
    check("exs.rel.pc", bus.PC_out, 16'h0030);
    check("exs.rel.imm", bus.imm16_out, 16'hFFE0);
    check("exs.rel.busy", dut.busy, 8'h40);
    bus.Valid_in = 1'b0; bus.wb_valid = 1'b1; bus.wb_dest = 3'd6;
    tick();
    bus.wb_valid = 1'b0;
    chk_bubble("exs.once");
    check("exs.once.busy", dut.busy, 8'h00);

    // flush alongside a write-back instruction to r5
    instr(16'h0040, 3'b001, 4'h4, 4'b0000, 4'b0000, 3'd5);
    bus.flush = 1'b1;
    tick();
    chk_bubble("flush");
    check("flush.busy", dut.busy, 8'h00);
    bus.flush = 1'b0;
    instr(16'h0044, 3'b000, 4'h4, 4'b1101, 4'b0000, 3'd1);
    #1;
    check("flush.r5.stall", bus.stall_out, 1'b0);
    tick();
    check("flush.r5.valid", bus.Valid_out, 1'b1);
    check("flush.r5.opA", bus.opA_out, 16'hA005);
    bus.flush = 1'b1; bus.ex_stall = 1'b1;
    tick();
    chk_bubble("flush.exs");
    bus.flush = 1'b0; bus.ex_stall = 1'b0;

    // set r2 busy; unused-source read of r2 does not stall
    instr(16'h0050, 3'b001, 4'h5, 4'b0000, 4'b0000, 3'd2);
    tick();
    check("r2.busy", dut.busy, 8'h04);
    instr(16'h0052, 3'b000, 4'h6, 4'b0010, 4'b0000, 3'd0);
    #1;
    check("unused.stall", bus.stall_out, 1'b0);
    tick();
    check("unused.opA", bus.opA_out, 16'h0000);
    // dest equals source: reads old value, no self-stall
    instr(16'h0054, 3'b001, 4'h7, 4'b1111, 4'b0000, 3'd7);
    #1;
    check("self.stall", bus.stall_out, 1'b0);
    tick();
    check("self.opA", bus.opA_out, 16'hA007);
    check("self.busy", dut.busy, 8'h84);

    // hazard on r2 then reset mid-stall
    instr(16'h0056, 3'b001, 4'h8, 4'b0000, 4'b1010, 3'd1);
    #1;
    check("haz.stall", bus.stall_out, 1'b1);
    tick();
    chk_bubble("haz");
    reset = 1'b1;
    tick();
    chk_reset("rst1");
    reset = 1'b0;
    #1;
    check("rst1.stall", bus.stall_out, 1'b0);
    tick();
    check("post.valid", bus.Valid_out, 1'b1);
    check("post.opB", bus.opB_out, 16'hA002);
    bus.Valid_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
